uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo_if.sv | 25 ++
 rtl/uart_rx_fifo.sv | 94 +++++++++
 tb/tb_uart_rx_fifo.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: bundles the receive-FIFO strobes, head byte and status.
// The FIFO uses the slave modport. The receiver and bus-decoder side uses
// the master modport.
interface uart_rx_fifo_if;
  logic        I_push;
  logic [7:0]  I_data;
  logic        I_pop;
  logic        I_clear_overflow;
  logic [7:0]  O_data;
  logic        O_empty;
  logic        O_full;
  logic [7:0]  O_count;
  logic        O_overflow;
  logic [15:0] O_status;

  modport master (
    output I_push, I_data, I_pop, I_clear_overflow,
    input  O_data, O_empty, O_full, O_count, O_overflow, O_status
  );

  modport slave (
    input  I_push, I_data, I_pop, I_clear_overflow,
    output O_data, O_empty, O_full, O_count, O_overflow, O_status
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead byte FIFO between uart_rx and the bus decoder.
// The depth is 2**DEPTH_LOG2. The pointers carry one extra MSB so that a
// full FIFO can be told apart from an empty one.
// Optional build macro UART_RX_FIFO_OVERFLOW_EN builds the sticky overflow
// flag. Without it, O_overflow and status bit 2 read 0 and I_clear_overflow
// is ignored. A push while full is dropped in both builds.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic           I_clk,
  input  logic           I_reset,
  uart_rx_fifo_if.slave  bus
);
  localparam int             PW       = DEPTH_LOG2 + 1;
  localparam int             DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [PW-1:0]  PTR_ONE  = PW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count;
  logic          empty, full;
  logic          push_acc, pop_acc, overflow_event;
  logic          overflow;

  // Occupancy decode and the accept conditions for push and pop.
  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
               (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
    pop_acc  = bus.I_pop && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    push_acc = bus.I_push && (!full || pop_acc);
    overflow_event = bus.I_push && full && !pop_acc;
  end

  // Next pointer values.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers. Reset discards all buffered bytes.
  always_ff @(posedge I_clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (I_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array write.
  // NOTE: the array has no reset. Bytes that the pointers do not cover are never observed.
  always_ff @(posedge I_clk) begin
    if (!I_reset && push_acc) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= bus.I_data;
  end

`ifdef UART_RX_FIFO_OVERFLOW_EN
  logic overflow_q, overflow_d;

  // Sticky overflow flag. When a set and a clear arrive in the same cycle, the set wins.
  always_comb begin
    overflow_d = overflow_q;
    if (bus.I_clear_overflow) overflow_d = 1'b0;
    if (overflow_event)       overflow_d = 1'b1;
  end

  // Overflow flag register.
  always_ff @(posedge I_clk) begin
    if (I_reset) overflow_q <= 1'b0;
    else         overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`else
  logic unused_overflow_inputs;
  assign unused_overflow_inputs = bus.I_clear_overflow ^ overflow_event;
  assign overflow = 1'b0;
`endif

  assign bus.O_data     = empty ? 8'h00 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign bus.O_empty    = empty;
  assign bus.O_full     = full;
  assign bus.O_count    = 8'(count);
  assign bus.O_overflow = overflow;
  assign bus.O_status   = {8'(count), 5'b0, overflow, full, ~empty};
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo.
// DUT a uses DEPTH_LOG2=4. DUT b uses DEPTH_LOG2=2 for the wrap sequence.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef UART_RX_FIFO_OVERFLOW_EN
  localparam logic OV = 1'b1;
`else
  localparam logic OV = 1'b0;
`endif

  uart_rx_fifo_if bus_a ();
  uart_rx_fifo_if bus_b ();

  uart_rx_fifo #(.DEPTH_LOG2(4)) dut_a (.I_clk(clk), .I_reset(rst), .bus(bus_a));
  uart_rx_fifo #(.DEPTH_LOG2(2)) dut_b (.I_clk(clk), .I_reset(rst), .bus(bus_b));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] d);
    bus_a.I_push = 1'b1; bus_a.I_data = d;
    step();
    bus_a.I_push = 1'b0;
  endtask

  // Check the head byte, which the bus reads in the same cycle, then pop it.
  task automatic pop_a(input string tag, input logic [7:0] exp);
    check(tag, 32'(bus_a.O_data), 32'(exp));
    bus_a.I_pop = 1'b1;
    step();
    bus_a.I_pop = 1'b0;
  endtask

  logic [7:0] model_q[$];

  initial begin
    bus_a.I_push = 0; bus_a.I_data = 0; bus_a.I_pop = 0; bus_a.I_clear_overflow = 0;
    bus_b.I_push = 0; bus_b.I_data = 0; bus_b.I_pop = 0; bus_b.I_clear_overflow = 0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state, then idle.
    check("rst_status", 32'(bus_a.O_status), 32'h0000);
    check("rst_empty",  32'(bus_a.O_empty),  32'h1);
    check("rst_data",   32'(bus_a.O_data),   32'h00);

    // A pop while empty changes nothing.
    bus_a.I_pop = 1'b1; step(); bus_a.I_pop = 1'b0;
    check("pop_empty_status", 32'(bus_a.O_status), 32'h0000);

    // Two pushes, then two pops.
    push_a(8'hA5);
    push_a(8'h3C);
    check("two_data",   32'(bus_a.O_data),   32'hA5);
    check("two_count",  32'(bus_a.O_count),  32'd2);
    check("two_status", 32'(bus_a.O_status), 32'h0201);
    pop_a("pop1_head", 8'hA5);
    check("pop1_next", 32'(bus_a.O_data), 32'h3C);
    pop_a("pop2_head", 8'h3C);
    check("pop2_empty", 32'(bus_a.O_empty), 32'h1);

    // Fill to 16 entries, then overflow with 8'h10.
    for (int i = 0; i < 16; i++) push_a(8'(i));
    check("fill_full",  32'(bus_a.O_full),  32'h1);
    check("fill_count", 32'(bus_a.O_count), 32'd16);
    push_a(8'h10);
    check("ovf_flag",   32'(bus_a.O_overflow), 32'(OV));
    check("ovf_status", 32'(bus_a.O_status), {16'h0, 8'h10, 5'b0, OV, 2'b11});
    check("ovf_count",  32'(bus_a.O_count), 32'd16);

    // An overflow in the same cycle as a clear leaves the flag set.
    bus_a.I_clear_overflow = 1'b1;
    push_a(8'h11);
    bus_a.I_clear_overflow = 1'b0;
    check("set_wins", 32'(bus_a.O_overflow), 32'(OV));

    // A clear on its own drops the flag.
    bus_a.I_clear_overflow = 1'b1; step(); bus_a.I_clear_overflow = 1'b0;
    check("clear_ovf", 32'(bus_a.O_overflow), 32'h0);

    // Push and pop together while full: the head 00 leaves and 8'h77 goes in last.
    check("full_head", 32'(bus_a.O_data), 32'h00);
    bus_a.I_push = 1'b1; bus_a.I_data = 8'h77; bus_a.I_pop = 1'b1;
    step();
    bus_a.I_push = 1'b0; bus_a.I_pop = 1'b0;
    check("pp_full_count", 32'(bus_a.O_count), 32'd16);
    check("pp_full_ovf",   32'(bus_a.O_overflow), 32'h0);
    for (int i = 1; i < 16; i++) pop_a($sformatf("drain_%0d", i), 8'(i));
    pop_a("drain_last", 8'h77);
    check("drain_empty", 32'(bus_a.O_empty), 32'h1);

    // Push and pop together while empty: the push is accepted and the pop is ignored.
    bus_a.I_push = 1'b1; bus_a.I_data = 8'h5A; bus_a.I_pop = 1'b1;
    step();
    bus_a.I_push = 1'b0; bus_a.I_pop = 1'b0;
    check("pp_empty_count", 32'(bus_a.O_count), 32'd1);
    check("pp_empty_data",  32'(bus_a.O_data),  32'h5A);

    // Reset with 5 entries buffered and a coincident push.
    for (int i = 0; i < 4; i++) push_a(8'(8'hC0 + i));
    check("pre_rst_count", 32'(bus_a.O_count), 32'd5);
    rst = 1'b1; bus_a.I_push = 1'b1; bus_a.I_data = 8'hEE;
    step();
    rst = 1'b0; bus_a.I_push = 1'b0;
    check("mid_rst_count",  32'(bus_a.O_count),  32'd0);
    check("mid_rst_empty",  32'(bus_a.O_empty),  32'h1);
    check("mid_rst_status", 32'(bus_a.O_status), 32'h0000);

    // Wrap on the depth-4 instance: 40 push/pop pairs, with the count running 0..3.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      d = 8'((i * 37 + 11) & 8'hFF);
      bus_b.I_push = 1'b1; bus_b.I_data = d;
      step();
      bus_b.I_push = 1'b0;
      model_q.push_back(d);
      check("wrap_count_push", 32'(bus_b.O_count), 32'(model_q.size()));
      if (model_q.size() == 3 || i == 39) begin
        while (model_q.size() > 0) begin
          check("wrap_head", 32'(bus_b.O_data), 32'(model_q.pop_front()));
          bus_b.I_pop = 1'b1; step(); bus_b.I_pop = 1'b0;
          check("wrap_count_pop", 32'(bus_b.O_count), 32'(model_q.size()));
        end
      end
    end
    check("wrap_empty", 32'(bus_b.O_empty), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
